// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling from a
// down-counting baud timer, one-cycle strobes for good bytes and framing errors.
module uart_rx #(
  parameter int M = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rcv,
  output logic       busy,
  output logic       ferr
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(M / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(M - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  logic          rx_p0;
  logic          rxs;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sr;
  logic          tick;

  assign tick = (cnt == '0);

  // Stage p0/p1: synchronizer; the FSM below only ever looks at rxs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      data  <= 8'h00;
      rcv   <= 1'b0;
      ferr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rx_p0 <= rx;
      rxs   <= rx_p0;
      rcv   <= 1'b0;
      ferr  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= HALF_LD;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (!rxs) begin
              state <= DATA;
              cnt   <= FULL_LD;
              idx   <= '0;
            end else begin
              // Start bit gone by mid-bit: line glitch, not a frame.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            sr  <= {rxs, sr[7:1]};
            cnt <= FULL_LD;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            busy <= 1'b0;
            if (rxs) begin
              data  <= sr;
              rcv   <= 1'b1;
              state <= IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= BRK;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BRK: begin
          // Hold off until the line returns high so a break cannot retrigger.
          if (rxs) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are generated bit-by-bit at the line
// level and outputs are checked against an expected-event queue.
module tb_uart_rx;

  localparam int M = 104;
  localparam int LAT = 3 + M / 2 + 9 * M;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       busy;
  logic       ferr;

  uart_rx #(.M(M)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (data),
    .rcv  (rcv),
    .busy (busy),
    .ferr (ferr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] d;
    int         fall;
  } exp_t;

  exp_t       exp_q[$];
  int         rcv_t[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         n_rcv = 0;
  int         n_ferr = 0;
  int         busy_cnt = 0;
  logic [7:0] last_good = 8'h00;
  exp_t       e_mon;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    chk(tag, (obs >= lo && obs <= hi) ? lo : obs, lo);
  endtask

  // Event monitor: every strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (rcv || ferr) begin
      chk("excl", {31'd0, rcv & ferr}, 0);
      if (exp_q.size() == 0) begin
        chk("unexp_evt", {30'd0, rcv, ferr}, 0);
      end else begin
        e_mon = exp_q.pop_front();
        chk("kind", {31'd0, ferr}, {31'd0, e_mon.is_err});
        chk_rng("lat", cyc - e_mon.fall, LAT - 1, LAT + 1);
        if (rcv) begin
          chk("data", {24'd0, data}, {24'd0, e_mon.d});
          last_good = e_mon.d;
          rcv_t.push_back(cyc);
          n_rcv++;
        end else begin
          chk("held", {24'd0, data}, {24'd0, last_good});
          n_ferr++;
        end
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on a negedge with the stop level still driven.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_ok);
    exp_t       e;
    logic [9:0] bits;
    bits     = {stop_ok, b, 1'b0};
    e.is_err = !stop_ok;
    e.d      = b;
    e.fall   = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         r0, f0;
    logic [7:0] b, prev;
    int         p;
    logic       ok;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data}, 0);
    chk("rst_rcv", {31'd0, rcv}, 0);
    chk("rst_ferr", {31'd0, ferr}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    idle(20);

    // Single 'K' frame
    busy_cnt = 0; r0 = n_rcv; f0 = n_ferr;
    send_frame(8'h4B, M, 1'b1);
    idle(20);
    drain("k_drain");
    chk("k_rcv", n_rcv - r0, 1);
    chk("k_ferr", n_ferr - f0, 0);
    chk("k_data", {24'd0, data}, 8'h4B);
    chk_rng("k_busy_len", busy_cnt, (19 * M) / 2 - 2, (19 * M) / 2 + 2);

    // Back-to-back frames, no idle gap
    rcv_t.delete();
    send_frame(8'h00, M, 1'b1);
    send_frame(8'hFF, M, 1'b1);
    send_frame(8'h55, M, 1'b1);
    idle(20);
    drain("b2b_drain");
    chk("b2b_count", rcv_t.size(), 3);
    for (int i = 1; i < rcv_t.size(); i++)
      chk_rng("b2b_space", rcv_t[i] - rcv_t[i-1], 10 * M - 2, 10 * M + 2);
    chk("b2b_data", {24'd0, data}, 8'h55);

    // 30-cycle glitch
    busy_cnt = 0; r0 = n_rcv; f0 = n_ferr;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    idle(70);
    chk_rng("glitch_busy_len", busy_cnt, 1, 55);
    chk("glitch_busy_end", {31'd0, busy}, 0);
    chk("glitch_rcv", n_rcv - r0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);

    // Framing error followed by a long break
    prev = last_good; r0 = n_rcv; f0 = n_ferr;
    send_frame(8'hA5, M, 1'b0);
    repeat (3000) @(negedge clk);
    chk("brk_busy", {31'd0, busy}, 0);
    chk("brk_ferr", n_ferr - f0, 1);
    chk("brk_rcv", n_rcv - r0, 0);
    chk("brk_data", {24'd0, data}, {24'd0, prev});
    idle(20);
    send_frame(8'h3C, M, 1'b1);
    idle(20);
    drain("brk_drain");
    chk("brk_next", {24'd0, data}, 8'h3C);

    // Reset during bit 4 of 0x81; the rest of that frame is abandoned
    r0 = n_rcv; f0 = n_ferr;
    b = 8'h81;
    rx = 1'b0;
    repeat (M) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (M) @(negedge clk);
    end
    rx = b[4];
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    rx = 1'b1;
    chk("rrst_data", {24'd0, data}, 0);
    chk("rrst_busy", {31'd0, busy}, 0);
    idle(1200);
    chk("rrst_rcv", n_rcv - r0, 0);
    chk("rrst_ferr", n_ferr - f0, 0);
    send_frame(8'h7E, M, 1'b1);
    idle(20);
    drain("rrst_drain");
    chk("rrst_next", {24'd0, data}, 8'h7E);

    // Baud mismatch of roughly +/-3 %
    r0 = n_rcv; f0 = n_ferr;
    send_frame(8'hC3, 101, 1'b1);
    idle(10);
    send_frame(8'hC3, 107, 1'b1);
    idle(20);
    drain("tol_drain");
    chk("tol_rcv", n_rcv - r0, 2);
    chk("tol_ferr", n_ferr - f0, 0);
    chk("tol_data", {24'd0, data}, 8'hC3);

    // Random frames: byte, bit period, stop-bit fault and gaps all drawn at random
    for (int k = 0; k < 20; k++) begin
      b  = 8'($urandom);
      p  = int'($urandom_range(101, 107));
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, p, ok);
      if (!ok) begin
        repeat ($urandom_range(0, 300)) @(negedge clk);
        idle(int'($urandom_range(4, 200)));
      end else begin
        idle(int'($urandom_range(0, 150)));
      end
    end
    idle(20);
    drain("rnd_drain");
    chk("rnd_data", {24'd0, data}, {24'd0, last_good});
    chk("rnd_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
